fifo_uart_tx: RTL

Drain stage directly downstream of the synchronous FIFO. It pops one byte at a time through the FIFO's read port (`r_en` / `data_out` / `empty`) and serializes each byte onto a UART line as 8N1, or 8E1 when parity is compiled in. It runs on the same clock as the FIFO and is the only reader of that FIFO.

---
 rtl/fifo_uart_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame and serializes it as 8N1 UART.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t                state;
   logic [BAUD_W-1:0]     baud_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shift;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                  parity_bit;
`endif

   wire baud_last = (baud_cnt == BAUD_LAST);

   // NOTE: every register here uses <= so all of them update from the same
   // pre-edge values; a blocking '=' would let later statements see new state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
         fifo_rd_en <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         fifo_rd_en <= 1'b0;
         tx_done    <= 1'b0;
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               if (!fifo_empty) begin
                  state      <= FETCH;
                  fifo_rd_en <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            FETCH: state <= LOAD;
            LOAD: begin
               // The FIFO presents the popped byte during this cycle.
               shift      <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
               parity_bit <= ^fifo_data;
`endif
               bit_cnt    <= '0;
               baud_cnt   <= '0;
               tx         <= 1'b0;
               state      <= START;
            end
            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  tx       <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                     tx    <= parity_bit;
                     state <= PARITY;
`else
                     tx    <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     // shift[1] becomes shift[0] after this edge's right shift.
                     tx <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  busy     <= 1'b0;
                  tx_done  <= 1'b1;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
